mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory-side stage driven by the controller FSM: owns the program counter, data-address register and instruction register, the 256x16 program/data RAM, and the memory-mapped switch/LED ports. It consumes the FSM strobes (`mem_cmd`, `addr_sel`, `load_pc`, `reset_pc`, `load_ir`, `load_addr`) and the datapath result `datapath_out`. It returns the instruction word to the decoder and memory read data (`mdata`) to the datapath.

## Interface
- `DATA_W`, 16: word width.
- `ADDR_W`, 9: memory address width.
- `RAM_WORDS`, 256: RAM depth; occupies addresses 0..RAM_WORDS-1.
- `INIT_FILE`, "data.txt": RAM `$readmemb` image.
- One clock; reset is synchronous and active-high.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_cmd` input 2: MNONE=00, MREAD=01, MWRITE=10; 11 is illegal.
- `addr_sel` input 1: 1 = address from PC, 0 = address from data-address register.
- `load_pc` input 1: PC update enable.
- `reset_pc` input 1: selects 0 instead of PC+1 when `load_pc` is asserted.
- `load_ir` input 1: capture `mdata` into IR.
- `load_addr` input 1: capture `datapath_out[8:0]` into data-address register.
- `datapath_out` input 16: C register; source of data addresses and store data.
- `sw` input 8: board switches.
- `ir` output 16: instruction register, to decoder.
- `mdata` output 16: registered read data, to datapath vsel input and IR.
- `pc` output 9: program counter.
- `mem_addr` output 9: current memory address (combinational mux).
- `ledr` output 8: LED register.
- `mem_err` output 1: sticky illegal-access flag.

## Operation
- `mem_addr = addr_sel ? pc : daddr`.
- PC: if `load_pc`, then `pc <= reset_pc ? 0 : pc+1` (9-bit, 0x1FF wraps to 0x000). Otherwise PC holds. `reset_pc` has no effect without `load_pc`.
- daddr: `daddr <= datapath_out[8:0]` when `load_addr` is asserted; upper bits are ignored.
- IR: `ir <= mdata` when `load_ir` is asserted. IR is independent of PC; both may load in the same cycle.
- Read decode, registered into `mdata` on MREAD:
  - `mem_addr < RAM_WORDS`: RAM[mem_addr].
  - `mem_addr == 0x140`: `{8'h00, sw}`.
  - Any other address: 16'h0000.
- `mdata` holds its value when `mem_cmd` is not MREAD.
- Write decode on MWRITE:
  - `mem_addr < RAM_WORDS`: RAM[mem_addr] <= `datapath_out`.
  - `mem_addr == 0x100`: `ledr <= datapath_out[7:0]`.
  - Any other address: ignored, and `mem_err` is set.
- `mem_cmd == 11`: no read, no write, `mem_err` is set.
- `mem_err` clears only on reset.
- Reset: `pc`=0, `daddr`=0, `ir`=0, `mdata`=0, `ledr`=0, `mem_err`=0. RAM contents are not reset. A write presented in the reset cycle is suppressed.

## Timing
- Read latency is 1 cycle. Address and MREAD presented in cycle N give `mdata` valid from the edge ending N.
- Fetch sequence:
  - IF1: `addr_sel`=1, MREAD; `mdata` <= RAM[pc].
  - IF2: `load_ir`=1; `ir` <= instruction at end of IF2.
  - UpdatePC: `load_pc`=1; pc+1.
- Load sequence: `load_addr` in cycle N. MREAD with `addr_sel`=0 in N+1. `mdata` is valid in N+2 for the register write.
- A write commits at the edge ending its cycle. A read of the same address in the next cycle returns the new data (no read-during-write case, since the encoding excludes it).
- `sw` is sampled only on MREAD to 0x140; no synchroniser is included here.

## Structure
- Package `mem_pkg` holds:
  - `mem_cmd_t` enum (MNONE/MREAD/MWRITE).
  - `LED_ADDR`=9'h100 and `SW_ADDR`=9'h140.
  - Word and address widths.
- The FSM imports the same package.
- Sub-module `ram`: single-port, synchronous write, registered read. Parameters: width, depth, `INIT_FILE`.
- PC, daddr, IR, LED, `mdata` mux and error logic live in `mem_ctrl`.

## Test plan
- Reset, then `load_pc`+`reset_pc` -> `pc`=0. Three `load_pc` pulses -> `pc`=3. Force `pc`=0x1FF, pulse `load_pc` -> `pc`=0x000.
- RAM[0]=16'hD105: IF1 (MREAD, `addr_sel`=1) then IF2 with `load_ir` -> `ir`=16'hD105 after IF2 edge; `mdata` unchanged when MNONE follows.
- `datapath_out`=16'h0023, `load_addr`, then MWRITE with `datapath_out`=16'hBEEF, then MREAD from daddr -> `mdata`=16'hBEEF.
- `sw`=8'hA5, daddr=0x140, MREAD -> `mdata`=16'h00A5. daddr=0x100, MWRITE with 16'h1234 -> `ledr`=8'h34, RAM untouched.
- MWRITE to 0x1F0 -> no state change, `mem_err`=1 and stays 1. `mem_cmd`=11 also sets it. Reset -> `mem_err`=0.
- Assert `reset` during a MWRITE to address 5 -> RAM[5] unchanged, all registers 0 on the next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory command encoding, I/O addresses and widths
package mem_pkg;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 9;
  typedef enum logic [1:0] {MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10} mem_cmd_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_SW} rd_src_t;
  localparam logic [MEM_ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [MEM_ADDR_W-1:0] SW_ADDR = 9'h140;
endpackage

// File: rtl/mem_ctrl_ram.sv
// ram: single-port RAM with synchronous write and registered read
module ram
  import mem_pkg::*;
#(
  parameter int WIDTH = MEM_DATA_W,
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  // write commits at the edge; read data is held until the next read
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= d;
    if (re) q <= r_mem[addr];
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: PC/daddr/IR registers, RAM and memory-mapped switch/LED ports
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int RAM_WORDS = 256,
  parameter string INIT_FILE = "data.txt"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic              addr_sel,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_ir,
  input  logic              load_addr,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        ledr,
  output logic              mem_err
);
  localparam int RA_W = $clog2(RAM_WORDS);
  localparam logic [ADDR_W:0] RAM_LIM = (ADDR_W+1)'(RAM_WORDS);
  logic [ADDR_W-1:0] r_pc, r_daddr;
  logic [DATA_W-1:0] r_ir;
  logic [7:0]        r_ledr, r_sw;
  logic              r_err;
  rd_src_t           r_src;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_ram, w_rd, w_wr, w_ram_we, w_ram_re;
  logic [DATA_W-1:0] w_ram_q, w_mdata;
  // address mux, access decode and read-data source selection
  always_comb begin
    w_addr = addr_sel ? r_pc : r_daddr;
    w_in_ram = {1'b0, w_addr} < RAM_LIM;
    w_rd = mem_cmd == MREAD;
    w_wr = mem_cmd == MWRITE;
    w_ram_we = !reset && w_wr && w_in_ram;
    w_ram_re = !reset && w_rd && w_in_ram;
    w_mdata = r_src == SRC_RAM ? w_ram_q : r_src == SRC_SW ? {{(DATA_W-8){1'b0}}, r_sw} : '0;
  end
  ram #(.WIDTH(DATA_W), .DEPTH(RAM_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .clk (clk),
    .we  (w_ram_we),
    .re  (w_ram_re),
    .addr(w_addr[RA_W-1:0]),
    .d   (datapath_out),
    .q   (w_ram_q)
  );
  // architectural registers; r_src remembers which source the last read came from
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
      r_daddr <= '0;
      r_ir <= '0;
      r_ledr <= '0;
      r_sw <= '0;
      r_err <= 1'b0;
      r_src <= SRC_ZERO;
    end else begin
      if (load_pc) r_pc <= reset_pc ? '0 : r_pc + 1'b1;
      if (load_addr) r_daddr <= datapath_out[ADDR_W-1:0];
      if (load_ir) r_ir <= w_mdata;
      if (w_rd) r_src <= w_in_ram ? SRC_RAM : w_addr == SW_ADDR ? SRC_SW : SRC_ZERO;
      if (w_rd && w_addr == SW_ADDR) r_sw <= sw;
      if (w_wr && w_addr == LED_ADDR) r_ledr <= datapath_out[7:0];
      if ((w_wr && !w_in_ram && w_addr != LED_ADDR) || mem_cmd == 2'b11) r_err <= 1'b1;
    end
  end
  assign ir = r_ir;
  assign mdata = w_mdata;
  assign pc = r_pc;
  assign mem_addr = w_addr;
  assign ledr = r_ledr;
  assign mem_err = r_err;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl against a behavioural model
module tb_mem_ctrl;
  import mem_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = 2'b00;
  logic        addr_sel = 1'b0, load_pc = 1'b0, reset_pc = 1'b0, load_ir = 1'b0, load_addr = 1'b0;
  logic [15:0] datapath_out = 16'h0;
  logic [7:0]  sw = 8'h0;
  logic [15:0] ir, mdata;
  logic [8:0]  pc, mem_addr;
  logic [7:0]  ledr;
  logic        mem_err;

  mem_ctrl #(.INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .addr_sel(addr_sel), .load_pc(load_pc),
    .reset_pc(reset_pc), .load_ir(load_ir), .load_addr(load_addr), .datapath_out(datapath_out),
    .sw(sw), .ir(ir), .mdata(mdata), .pc(pc), .mem_addr(mem_addr), .ledr(ledr), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mdata, ir;
    logic [8:0]  pc, maddr;
    logic [7:0]  ledr;
    logic        err;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;

  logic [15:0] m_ram [256];
  logic [8:0]  m_pc = 0, m_daddr = 0;
  logic [15:0] m_ir = 0, m_md = 0;
  logic [7:0]  m_led = 0;
  logic        m_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("mdata", mdata, e.mdata);
      chk("ir", ir, e.ir);
      chk("pc", 16'(pc), 16'(e.pc));
      chk("mem_addr", 16'(mem_addr), 16'(e.maddr));
      chk("ledr", 16'(ledr), 16'(e.ledr));
      chk("mem_err", 16'(mem_err), 16'(e.err));
    end
  end

  task automatic step(input logic rst, input logic [1:0] cmd, input logic asel, input logic lpc,
                      input logic rpc, input logic lir, input logic ladr,
                      input logic [15:0] dout, input logic [7:0] swv);
    logic [8:0]  a;
    logic [15:0] old_md;
    exp_t e;
    @(negedge clk);
    reset = rst; mem_cmd = cmd; addr_sel = asel; load_pc = lpc; reset_pc = rpc;
    load_ir = lir; load_addr = ladr; datapath_out = dout; sw = swv;
    a = asel ? m_pc : m_daddr;
    old_md = m_md;
    if (rst) begin
      m_pc = 0; m_daddr = 0; m_ir = 0; m_md = 0; m_led = 0; m_err = 0;
    end else begin
      if (lir) m_ir = old_md;
      if (lpc) m_pc = rpc ? 9'h000 : m_pc + 9'h001;
      if (ladr) m_daddr = dout[8:0];
      if (cmd == 2'b01) m_md = a < 9'd256 ? m_ram[a[7:0]] : a == 9'h140 ? {8'h00, swv} : 16'h0000;
      if (cmd == 2'b10) begin
        if (a < 9'd256) m_ram[a[7:0]] = dout;
        else if (a == 9'h100) m_led = dout[7:0];
        else m_err = 1'b1;
      end
      if (cmd == 2'b11) m_err = 1'b1;
    end
    e.mdata = m_md; e.ir = m_ir; e.pc = m_pc; e.maddr = asel ? m_pc : m_daddr;
    e.ledr = m_led; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic nop();
    step(0, 2'b00, 0, 0, 0, 0, 0, 16'h0, 8'h0);
  endtask

  task automatic set_daddr(input logic [15:0] v);
    step(0, 2'b00, 0, 0, 0, 0, 1, v, 8'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int r;
    logic [1:0] c;
    step(1, 2'b00, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    step(0, 2'b00, 1, 1, 1, 0, 0, 16'h0, 8'h0);
    repeat (3) step(0, 2'b00, 1, 1, 0, 0, 0, 16'h0, 8'h0);
    step(0, 2'b00, 1, 0, 1, 0, 0, 16'h0, 8'h0);
    repeat (508) step(0, 2'b00, 1, 1, 0, 0, 0, 16'h0, 8'h0);
    step(0, 2'b00, 1, 1, 0, 0, 0, 16'h0, 8'h0);
    for (int a = 0; a < 256; a++) begin
      set_daddr(16'(a));
      step(0, 2'b10, 0, 0, 0, 0, 0, a == 0 ? 16'hD105 : 16'($urandom), 8'h0);
    end
    step(0, 2'b01, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    step(0, 2'b00, 1, 0, 0, 1, 0, 16'h0, 8'h0);
    step(0, 2'b00, 1, 1, 0, 0, 0, 16'h0, 8'h0);
    nop();
    set_daddr(16'h0023);
    step(0, 2'b10, 0, 0, 0, 0, 0, 16'hBEEF, 8'h0);
    step(0, 2'b01, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    nop();
    set_daddr(16'hFF40);
    step(0, 2'b01, 0, 0, 0, 0, 0, 16'h0, 8'hA5);
    set_daddr(16'h0100);
    step(0, 2'b10, 0, 0, 0, 0, 0, 16'h1234, 8'h0);
    set_daddr(16'h0000);
    step(0, 2'b01, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    set_daddr(16'h01F0);
    step(0, 2'b10, 0, 0, 0, 0, 0, 16'h5555, 8'h0);
    nop();
    step(0, 2'b01, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    step(0, 2'b11, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    nop();
    step(1, 2'b00, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    set_daddr(16'h0005);
    step(1, 2'b10, 0, 0, 0, 0, 0, ~m_ram[5], 8'h0);
    set_daddr(16'h0005);
    step(0, 2'b01, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    nop();
    repeat (1500) begin
      r = int'($urandom_range(0, 99));
      c = r < 35 ? 2'b01 : r < 65 ? 2'b10 : r < 97 ? 2'b00 : 2'b11;
      d = 16'($urandom);
      case ($urandom_range(0, 7))
        0: d[8:0] = 9'h100;
        1: d[8:0] = 9'h140;
        2: d[8:0] = 9'(9'h100 | 9'($urandom_range(0, 255)));
        default: d[8] = 1'b0;
      endcase
      step($urandom_range(0, 63) == 0, c, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), d, 8'($urandom));
    end
    nop();
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
